// File: rtl/dma_line_packer.sv
// Memory-to-host line packer: reads runs of words from the memory DMA port one
// request at a time and pushes every CL_WIDTH/WORD_WIDTH words as one cache line.
module dma_line_packer #(
    parameter int CL_WIDTH    = 512,
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 28,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] num_lines,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_en,
    output logic                   mem_wr_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [WORD_WIDTH-1:0]  mem_rd_data,
    input  logic                   mem_valid,
    input  logic                   full,
    output logic [CL_WIDTH-1:0]    wr_data,
    output logic                   wr_en
);

    localparam int WPL   = CL_WIDTH / WORD_WIDTH;
    localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH, S_DONE} state_t;

    state_t                         state;
    state_t                         state_next;
    logic [IDX_W-1:0]               word_idx;
    logic [COUNT_WIDTH-1:0]         lines_left;
    logic [WPL-1:0][WORD_WIDTH-1:0] line_buf;
    logic                           last_word;

    assign last_word = (word_idx == IDX_W'(WPL - 1));
    assign wr_data   = line_buf;
    assign mem_wr_en = 1'b0;

    // NOTE: every output and next-state gets a default before the case, so no
    // path through this block can leave a latch behind.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_en     = 1'b0;
        wr_en      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = (num_lines != '0) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                busy       = 1'b1;
                mem_en     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mem_valid) state_next = last_word ? S_PUSH : S_REQ;
            end
            S_PUSH: begin
                busy = 1'b1;
                if (!full) begin
                    wr_en      = 1'b1;
                    state_next = (lines_left == COUNT_WIDTH'(1)) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: the line buffer is cleared on reset along with the counters so a
    // partially packed line never leaks into a later transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mem_addr   <= '0;
            word_idx   <= '0;
            lines_left <= '0;
            line_buf   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start && num_lines != '0) begin
                        mem_addr   <= base_addr;
                        word_idx   <= '0;
                        lines_left <= num_lines;
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        line_buf[word_idx] <= mem_rd_data;
                        mem_addr           <= mem_addr + ADDR_WIDTH'(1);
                        if (!last_word) word_idx <= word_idx + IDX_W'(1);
                    end
                end
                S_PUSH: begin
                    if (!full) begin
                        lines_left <= lines_left - COUNT_WIDTH'(1);
                        word_idx   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_line_packer.sv
// Bench for dma_line_packer: a latency-programmable memory responder, a host FIFO
// with programmable backpressure, and an address/data reference model per transfer.
module tb_dma_line_packer;

    localparam int CLW = 512;
    localparam int WW  = 32;
    localparam int AW  = 28;
    localparam int CW  = 16;
    localparam int WPL = CLW / WW;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [CW-1:0]  num_lines;
    logic           busy, done, mem_en, mem_wr_en, wr_en;
    logic [AW-1:0]  mem_addr;
    logic [WW-1:0]  mem_rd_data;
    logic           mem_valid, full;
    logic [CLW-1:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dma_line_packer #(.CL_WIDTH(CLW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_lines(num_lines),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_valid(mem_valid), .full(full),
        .wr_data(wr_data), .wr_en(wr_en)
    );

    // Memory contents are a pure function of address so expectations need no storage.
    function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a, input logic [WW-1:0] s);
        return WW'(a) ^ s;
    endfunction

    // Responder / host-FIFO knobs set by the tests
    int            lat = 1;
    int            bp  = 0;
    logic [WW-1:0] salt = '0;
    bit            stray_en = 1'b0;

    bit            pend;
    logic [AW-1:0] pend_addr;
    int            pend_cnt;
    int            full_cnt;
    int            words_issued;
    int            overlap_err;

    initial begin
        mem_valid = 1'b0; full = 1'b0; mem_rd_data = '0;
        pend = 1'b0; pend_cnt = 0; full_cnt = 0; words_issued = 0; overlap_err = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (pend) overlap_err++;
                pend = 1'b1; pend_addr = mem_addr; pend_cnt = lat;
            end
            if (busy === 1'b0 && !pend) words_issued = 0;
            @(posedge clk);
            #1;
            if (full_cnt > 0) begin full = 1'b1; full_cnt--; end
            else full = 1'b0;
            mem_valid = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    mem_valid   = 1'b1;
                    mem_rd_data = word_of(pend_addr, salt);
                    pend        = 1'b0;
                    words_issued++;
                    if (words_issued % WPL == 0) full_cnt = bp;
                end
            end
            if (stray_en && !mem_valid) begin
                mem_valid   = 1'($urandom_range(0, 1));
                mem_rd_data = $urandom;
            end
        end
    end

    // Passive recorder
    int             cyc = 0;
    logic [AW-1:0]  got_addr[$];
    int             got_addr_cyc[$];
    logic [CLW-1:0] got_line[$];
    int             got_wr_cyc[$];
    int             done_cyc[$];
    int             busy_cnt, x_cnt, unstable;
    logic [CLW-1:0] hold_data;
    bit             hold_valid = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if ($isunknown({busy, done, mem_en, wr_en, mem_addr})) x_cnt++;
        if (mem_en) begin got_addr.push_back(mem_addr); got_addr_cyc.push_back(cyc); end
        if (wr_en) begin got_line.push_back(wr_data); got_wr_cyc.push_back(cyc); end
        if (done) done_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (full && busy) begin
            if (hold_valid && wr_data !== hold_data) unstable++;
            hold_data  = wr_data;
            hold_valid = 1'b1;
        end else begin
            hold_valid = 1'b0;
        end
    end

    task automatic clear_rec();
        got_addr.delete(); got_addr_cyc.delete(); got_line.delete(); got_wr_cyc.delete();
        done_cyc.delete();
        busy_cnt = 0; x_cnt = 0; unstable = 0; overlap_err = 0;
    endtask

    // Returns t0 such that relative cycle = cyc - t0 + 1 (cycle 1 follows the accepting edge).
    task automatic start_xfer(input logic [AW-1:0] b, input logic [CW-1:0] n, output int t0);
        @(posedge clk); #1;
        base_addr = b; num_lines = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cyc.size() > 0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s done timeout: no done within %0d cycles", name, budget);
        end
    endtask

    // Compares recorded traffic with the reference model of one transfer.
    task automatic check_xfer(input string name, input logic [AW-1:0] b, input int n,
                              input int l, input int bpc, input logic [WW-1:0] s, input int t0);
        int period = WPL * (1 + l) + 1 + bpc;
        int last_wr = n * period;
        logic [AW-1:0]  a;
        logic [CLW-1:0] exp_line;

        n_checks++;
        if (got_addr.size() !== WPL * n) begin
            n_fail++;
            $display("FAIL %s request count: got %0d expected %0d", name, got_addr.size(), WPL * n);
        end
        for (int i = 0; i < got_addr.size() && i < WPL * n; i++) begin
            a = b + AW'(i);
            n_checks++;
            if (got_addr[i] !== a) begin
                n_fail++;
                $display("FAIL %s addr[%0d]: got %h expected %h", name, i, got_addr[i], a);
            end
        end
        n_checks++;
        if (got_line.size() !== n) begin
            n_fail++;
            $display("FAIL %s line count: got %0d expected %0d", name, got_line.size(), n);
        end
        for (int j = 0; j < got_line.size() && j < n; j++) begin
            for (int k = 0; k < WPL; k++) exp_line[WW*k +: WW] = word_of(b + AW'(j * WPL + k), s);
            n_checks++;
            if (got_line[j] !== exp_line) begin
                n_fail++;
                $display("FAIL %s line[%0d]: got %h expected %h", name, j, got_line[j], exp_line);
            end
        end
        n_checks++;
        if (got_addr_cyc.size() == 0 || got_addr_cyc[0] - t0 + 1 !== 1) begin
            n_fail++;
            $display("FAIL %s first mem_en cycle: got %0d expected 1", name,
                     got_addr_cyc.size() ? got_addr_cyc[0] - t0 + 1 : -1);
        end
        n_checks++;
        if (got_wr_cyc.size() == 0 || got_wr_cyc[$] - t0 + 1 !== last_wr) begin
            n_fail++;
            $display("FAIL %s last wr_en cycle: got %0d expected %0d", name,
                     got_wr_cyc.size() ? got_wr_cyc[$] - t0 + 1 : -1, last_wr);
        end
        n_checks++;
        if (done_cyc.size() !== 1 || done_cyc[0] - t0 + 1 !== last_wr + 1) begin
            n_fail++;
            $display("FAIL %s done cycle: got %0d (pulses %0d) expected %0d", name,
                     done_cyc.size() ? done_cyc[0] - t0 + 1 : -1, done_cyc.size(), last_wr + 1);
        end
        n_checks++;
        if (busy_cnt !== last_wr) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, last_wr);
        end
        n_checks++;
        if (overlap_err !== 0 || unstable !== 0 || x_cnt !== 0) begin
            n_fail++;
            $display("FAIL %s protocol: overlap %0d unstable %0d x %0d expected all 0",
                     name, overlap_err, unstable, x_cnt);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({busy, done, mem_en, mem_wr_en, wr_en} !== 5'b0 || mem_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: busy %b done %b mem_en %b mem_wr_en %b wr_en %b addr %h data %h expected all 0",
                     name, busy, done, mem_en, mem_wr_en, wr_en, mem_addr, wr_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
    endtask

    task automatic test_idle_valid();
        clear_rec();
        stray_en = 1'b1;
        repeat (8) @(posedge clk);
        #1 stray_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (got_line.size() !== 0 || got_addr.size() !== 0 || busy_cnt !== 0 || done_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_valid activity: lines %0d reqs %0d busy %0d done %0d expected 0",
                     got_line.size(), got_addr.size(), busy_cnt, done_cyc.size());
        end
        check_outputs_zero("idle_valid");
    endtask

    task automatic test_single_line();
        int t0;
        lat = 1; bp = 0; salt = '0;
        clear_rec();
        start_xfer(AW'(28'h100), CW'(1), t0);
        repeat (5) @(posedge clk);
        #1 start = 1'b1; base_addr = AW'(28'h200); num_lines = CW'(5);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("single_line", 200);
        check_xfer("single_line", AW'(28'h100), 1, 1, 0, '0, t0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_addr.size() !== WPL || done_cyc.size() !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy: reqs %0d dones %0d busy %b expected %0d 1 0",
                     got_addr.size(), done_cyc.size(), busy, WPL);
        end
    endtask

    task automatic test_backpressure();
        int t0;
        lat = 3; bp = 5; salt = '0;
        clear_rec();
        start_xfer('0, CW'(3), t0);
        wait_done("backpressure", 600);
        check_xfer("backpressure", '0, 3, 3, 5, '0, t0);
        bp = 0;
    endtask

    task automatic test_wrap();
        int t0;
        lat = 1; bp = 0; salt = $urandom;
        clear_rec();
        start_xfer(AW'(28'hFFFFFF8), CW'(1), t0);
        wait_done("wrap", 200);
        check_xfer("wrap", AW'(28'hFFFFFF8), 1, 1, 0, salt, t0);
    endtask

    task automatic test_zero_lines();
        int t0;
        clear_rec();
        start_xfer(AW'(28'h55), CW'(0), t0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_lines cycle1: done %b busy %b expected 1 0", done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_lines cycle2: done %b expected 0", done);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_addr.size() !== 0 || busy_cnt !== 0 || done_cyc.size() !== 1 || got_line.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_lines activity: reqs %0d busy %0d dones %0d lines %0d expected 0 0 1 0",
                     got_addr.size(), busy_cnt, done_cyc.size(), got_line.size());
        end
    endtask

    task automatic test_reset_mid();
        int  t0;
        bit  ok = 1'b0;
        lat = 1; bp = 0; salt = '0;
        clear_rec();
        start_xfer(AW'(28'h40), CW'(2), t0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (words_issued >= 10) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_mid wait: words %0d expected 10 within 100 cycles", words_issued);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_mid");
        repeat (40) @(negedge clk);
        n_checks++;
        if (got_line.size() !== 0 || got_addr.size() !== 11 || done_cyc.size() !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid after: lines %0d reqs %0d dones %0d busy %b expected 0 11 0 0",
                     got_line.size(), got_addr.size(), done_cyc.size(), busy);
        end
        check_outputs_zero("reset_mid_late_valid");
    endtask

    task automatic test_random();
        int            t0, n, l, bpc;
        logic [AW-1:0] b;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 3); l = $urandom_range(1, 4); bpc = $urandom_range(0, 3);
            b = AW'($urandom); salt = $urandom;
            lat = l; bp = bpc;
            clear_rec();
            start_xfer(b, CW'(n), t0);
            wait_done($sformatf("random%0d", it), 2000);
            check_xfer($sformatf("random%0d", it), b, n, l, bpc, salt, t0);
            repeat (3) @(posedge clk);
        end
        bp = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_valid();
        test_single_line();
        test_backpressure();
        test_wrap();
        test_zero_lines();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
